// File: rtl/alu_decode_pkg.sv
// alu_decode_pkg: ALU control encodings, aluop/funct codes and decoded-lane type shared by the decode stage.
package alu_decode_pkg;
  localparam logic [2:0] AC_AND = 3'b000;
  localparam logic [2:0] AC_OR  = 3'b001;
  localparam logic [2:0] AC_ADD = 3'b010;
  localparam logic [2:0] AC_XOR = 3'b011;
  localparam logic [2:0] AC_SUB = 3'b110;
  localparam logic [2:0] AC_SLT = 3'b111;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_RTYPE = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_ADDIU = 4'b0111;
  localparam logic [3:0] OP_SLTIU = 4'b1000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  // The all-zero pattern is produced only by illegal codes, so it doubles as the illegal marker.
  typedef struct packed {
    logic [2:0] alucontrol;
    logic       signd;
    logic       multseld;
  } lane_dec_t;
  localparam lane_dec_t DEC_ILLEGAL = '0;
  function automatic lane_dec_t mk(input logic [2:0] ac, input logic s, input logic m);
    return '{alucontrol: ac, signd: s, multseld: m};
  endfunction
endpackage

// File: rtl/alu_decode_lane.sv
// alu_decode_lane: combinational decode of one lane's aluop/funct into alucontrol, signd, multseld.
// Ports: aluop[3:0], funct[5:0] in; dec (lane_dec_t) out, all-zero for illegal codes.
module alu_decode_lane
  import alu_decode_pkg::*;
(
  input  logic [3:0] aluop,
  input  logic [5:0] funct,
  output lane_dec_t  dec
);
  always_comb begin
    dec = DEC_ILLEGAL;
    case (aluop)
      OP_ADD:   dec = mk(AC_ADD, 1'b1, 1'b0);
      OP_SUB:   dec = mk(AC_SUB, 1'b1, 1'b0);
      OP_OR:    dec = mk(AC_OR,  1'b1, 1'b0);
      OP_AND:   dec = mk(AC_AND, 1'b1, 1'b0);
      OP_XOR:   dec = mk(AC_XOR, 1'b1, 1'b0);
      OP_SLT:   dec = mk(AC_SLT, 1'b1, 1'b0);
      OP_ADDIU: dec = mk(AC_ADD, 1'b0, 1'b0);
      OP_SLTIU: dec = mk(AC_SLT, 1'b0, 1'b0);
      OP_RTYPE:
        case (funct)
          FN_ADD:   dec = mk(AC_ADD, 1'b1, 1'b0);
          FN_ADDU:  dec = mk(AC_ADD, 1'b0, 1'b0);
          FN_SUB:   dec = mk(AC_SUB, 1'b1, 1'b0);
          FN_SUBU:  dec = mk(AC_SUB, 1'b0, 1'b0);
          FN_AND:   dec = mk(AC_AND, 1'b1, 1'b0);
          FN_OR:    dec = mk(AC_OR,  1'b1, 1'b0);
          FN_SLT:   dec = mk(AC_SLT, 1'b1, 1'b0);
          FN_SLTU:  dec = mk(AC_SLT, 1'b0, 1'b0);
          FN_XOR:   dec = mk(AC_XOR, 1'b1, 1'b0);
          FN_MULT:  dec = mk(AC_AND, 1'b1, 1'b1);
          FN_MULTU: dec = mk(AC_AND, 1'b0, 1'b1);
          default:  dec = DEC_ILLEGAL;
        endcase
      default:  dec = DEC_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: multi-lane registered ALU decode with valid/ready handshake and shared-multiplier occupancy.
// Ports: clk, reset_n (async, active-low); in_valid/in_ready, funct, aluop, flush upstream;
// out_valid/out_ready, alucontrol, signd, multseld downstream; mult_busy.
// Define ALU_DECODE_ILLEGAL_EN to add the per-lane illegal output.
module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int MULT_LAT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LANES-1:0]   in_valid,
  output logic               in_ready,
  input  logic [6*LANES-1:0] funct,
  input  logic [4*LANES-1:0] aluop,
  input  logic               flush,
  output logic [LANES-1:0]   out_valid,
  input  logic               out_ready,
  output logic [3*LANES-1:0] alucontrol,
  output logic [LANES-1:0]   signd,
  output logic [LANES-1:0]   multseld,
`ifdef ALU_DECODE_ILLEGAL_EN
  output logic [LANES-1:0]   illegal,
`endif
  output logic               mult_busy
);
  localparam int CW = MULT_LAT > 1 ? $clog2(MULT_LAT) : 1;
  lane_dec_t raw [LANES];
  lane_dec_t lane [LANES];
  lane_dec_t q [LANES];
  logic [CW-1:0] cnt;
  logic any_mult, acc;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    alu_decode_lane u_lane (
      .aluop(aluop[4*i+:4]),
      .funct(funct[6*i+:6]),
      .dec  (raw[i])
    );
    assign alucontrol[3*i+:3] = q[i].alucontrol;
    assign signd[i]           = q[i].signd;
    assign multseld[i]        = q[i].multseld;
`ifdef ALU_DECODE_ILLEGAL_EN
    assign illegal[i]         = out_valid[i] && q[i] == DEC_ILLEGAL;
`endif
  end
  // Only the lowest valid mult lane keeps the multiplier; later mult lanes become illegal.
  always_comb begin
    any_mult = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane[i] = in_valid[i] ? raw[i] : DEC_ILLEGAL;
      if (any_mult && lane[i].multseld) lane[i] = DEC_ILLEGAL;
      any_mult = any_mult | lane[i].multseld;
    end
  end
  assign mult_busy = cnt != '0;
  assign in_ready  = reset_n && !flush && !(mult_busy && any_mult) && (out_valid == '0 || out_ready);
  assign acc       = in_ready && |in_valid;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= '0;
      q         <= '{default: DEC_ILLEGAL};
      cnt       <= '0;
    end else begin
      cnt <= (acc && any_mult) ? CW'(MULT_LAT - 1) : (mult_busy ? cnt - CW'(1) : cnt);
      if (acc) begin
        out_valid <= in_valid;
        q         <= lane;
      end else if (flush || out_ready) begin
        out_valid <= '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed and random checks of alu_decode_stage against a table-driven reference model.
module tb_alu_decode_stage;
  localparam int L  = 2;
  localparam int ML = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [L-1:0] in_valid = '0;
  logic in_ready;
  logic [6*L-1:0] funct = '0;
  logic [4*L-1:0] aluop = '0;
  logic flush = 1'b0, out_ready = 1'b0;
  logic [L-1:0] out_valid, signd, multseld;
  logic [3*L-1:0] alucontrol;
  logic mult_busy;
`ifdef ALU_DECODE_ILLEGAL_EN
  logic [L-1:0] illegal;
`endif
  int checks = 0, errors = 0;
  logic [L-1:0] m_ov = '0;
  logic [2:0] m_ac [L];
  logic m_s [L], m_m [L], m_il [L];
  int m_cnt = 0;
  // {rtype, key[5:0], alucontrol[2:0], signd, multseld}; key is funct for R-type, else zero-extended aluop
  logic [11:0] tbl [19];
  logic [5:0] fns [12];

  alu_decode_stage #(.LANES(L), .MULT_LAT(ML)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .aluop(aluop), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alucontrol(alucontrol), .signd(signd), .multseld(multseld),
`ifdef ALU_DECODE_ILLEGAL_EN
    .illegal(illegal),
`endif
    .mult_busy(mult_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_dec(input logic [3:0] op, input logic [5:0] fn,
                                  output logic [2:0] ac, output logic s, output logic m, output logic il);
    logic [6:0] key;
    key = (op == 4'd2) ? {1'b1, fn} : {1'b0, 2'b00, op};
    ac = 3'b000; s = 1'b0; m = 1'b0; il = 1'b1;
    for (int k = 0; k < 19; k++)
      if (tbl[k][11:5] == key) begin
        {ac, s, m} = tbl[k][4:0];
        il = 1'b0;
      end
  endfunction

  function automatic logic offered_mult();
    logic [2:0] ac;
    logic s, m, il, r;
    r = 1'b0;
    for (int i = 0; i < L; i++) begin
      ref_dec(aluop[4*i+:4], funct[6*i+:6], ac, s, m, il);
      if (in_valid[i] && m) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic model_ready();
    return (m_ov == '0 || out_ready) && !(m_cnt > 0 && offered_mult()) && !flush;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".mult_busy"}, 32'(mult_busy), 32'(m_cnt != 0));
    for (int i = 0; i < L; i++) begin
      if (m_ov[i]) begin
        chk($sformatf("%s.alucontrol[%0d]", tag, i), 32'(alucontrol[3*i+:3]), 32'(m_ac[i]));
        chk($sformatf("%s.signd[%0d]", tag, i), 32'(signd[i]), 32'(m_s[i]));
        chk($sformatf("%s.multseld[%0d]", tag, i), 32'(multseld[i]), 32'(m_m[i]));
      end
`ifdef ALU_DECODE_ILLEGAL_EN
      chk($sformatf("%s.illegal[%0d]", tag, i), 32'(illegal[i]), 32'(m_ov[i] && m_il[i]));
`endif
    end
  endtask

  task automatic step(input string tag);
    logic acc, granted;
    int nxt;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
    acc = model_ready() && |in_valid;
    @(posedge clk);
    nxt = m_cnt > 0 ? m_cnt - 1 : 0;
    if (acc) begin
      granted = 1'b0;
      for (int i = 0; i < L; i++) begin
        ref_dec(aluop[4*i+:4], funct[6*i+:6], m_ac[i], m_s[i], m_m[i], m_il[i]);
        if (in_valid[i] && m_m[i] && granted) begin
          m_ac[i] = 3'b000; m_s[i] = 1'b0; m_m[i] = 1'b0; m_il[i] = 1'b1;
        end
        if (in_valid[i] && m_m[i]) granted = 1'b1;
      end
      m_ov = in_valid;
      if (granted) nxt = ML - 1;
    end else if (flush || out_ready) begin
      m_ov = '0;
    end
    m_cnt = nxt;
    #1;
    check_outs(tag);
  endtask

  task automatic drive(input logic [L-1:0] v, input logic [3:0] op0, input logic [5:0] fn0,
                       input logic [3:0] op1, input logic [5:0] fn1);
    in_valid = v;
    aluop = {op1, op0};
    funct = {fn1, fn0};
  endtask

  task automatic drain();
    drive('0, 4'd0, 6'd0, 4'd0, 6'd0);
    for (int k = 0; k < 20 && m_cnt != 0; k++) step("drain");
  endtask

  initial begin
    tbl = '{12'b0_000000_010_1_0, 12'b0_000001_110_1_0, 12'b0_000011_001_1_0, 12'b0_000100_000_1_0,
            12'b0_000101_011_1_0, 12'b0_000110_111_1_0, 12'b0_000111_010_0_0, 12'b0_001000_111_0_0,
            12'b1_100000_010_1_0, 12'b1_100001_010_0_0, 12'b1_100010_110_1_0, 12'b1_100011_110_0_0,
            12'b1_100100_000_1_0, 12'b1_100101_001_1_0, 12'b1_101010_111_1_0, 12'b1_101011_111_0_0,
            12'b1_100110_011_1_0, 12'b1_011000_000_1_1, 12'b1_011001_000_0_1};
    fns = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
            6'b101010, 6'b101011, 6'b100110, 6'b011000, 6'b011001, 6'b111111};
    for (int i = 0; i < L; i++) begin
      m_ac[i] = '0; m_s[i] = 0; m_m[i] = 0; m_il[i] = 0;
    end
    // reset state
    drive(2'b11, 4'd0, 6'd0, 4'd1, 6'd0);
    #12;
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.alucontrol", 32'(alucontrol), 0);
    chk("rst.signd", 32'(signd), 0);
    chk("rst.multseld", 32'(multseld), 0);
    chk("rst.mult_busy", 32'(mult_busy), 0);
`ifdef ALU_DECODE_ILLEGAL_EN
    chk("rst.illegal", 32'(illegal), 0);
`endif
    drive('0, 4'd0, 6'd0, 4'd0, 6'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    // R-type sub on lane 0
    out_ready = 1'b1;
    drive(2'b01, 4'b0010, 6'b100010, 4'd0, 6'd0);
    step("rsub");
    chk("rsub.ac0", 32'(alucontrol[2:0]), 3'b110);
    chk("rsub.signd0", 32'(signd[0]), 1);
    chk("rsub.ov0", 32'(out_valid[0]), 1);
    // mult occupancy: non-mult accepted meanwhile, second mult stalled until counter empties
    drive(2'b01, 4'b0010, 6'b011000, 4'd0, 6'd0);
    step("mult1");
    chk("mult1.busy", 32'(mult_busy), 1);
    drive(2'b11, 4'b0001, 6'd0, 4'b0101, 6'd0);
    step("nonmult_busy");
    drive(2'b10, 4'd0, 6'd0, 4'b0010, 6'b011001);
    step("mult2_stall_a");
    chk("mult2_stall_a.in_ready_low", 32'(in_ready), 0);
    step("mult2_stall_b");
    chk("mult2_stall_b.busy_done", 32'(mult_busy), 0);
    step("mult2_accept");
    chk("mult2_accept.busy", 32'(mult_busy), 1);
    drain();
    // two mult lanes: only lane 0 granted
    drive(2'b11, 4'b0010, 6'b011000, 4'b0010, 6'b011000);
    step("dualmult");
    chk("dualmult.multseld", 32'(multseld), 2'b01);
`ifdef ALU_DECODE_ILLEGAL_EN
    chk("dualmult.illegal", 32'(illegal), 2'b10);
`endif
    drain();
    // backpressure hold then back-to-back acceptance
    drive(2'b11, 4'b0110, 6'd0, 4'b1000, 6'd0);
    step("bp_load");
    out_ready = 1'b0;
    drive(2'b11, 4'b0011, 6'd0, 4'b0111, 6'd0);
    for (int k = 0; k < 5; k++) step("bp_hold");
    chk("bp_hold.in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    step("bp_release");
    drive(2'b11, 4'b0100, 6'd0, 4'b0010, 6'b101011);
    step("b2b_1");
    drive(2'b01, 4'b0010, 6'b100110, 4'd0, 6'd0);
    step("b2b_2");
    // flush during mult
    drive(2'b10, 4'd0, 6'd0, 4'b0010, 6'b011001);
    step("fl_mult");
    flush = 1'b1;
    drive(2'b01, 4'd0, 6'd0, 4'd0, 6'd0);
    step("flush");
    chk("flush.busy", 32'(mult_busy), 1);
    flush = 1'b0;
    step("post_flush");
    drain();
    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < L; i++) begin
        int sel;
        sel = $urandom_range(0, 10);
        aluop[4*i+:4] = sel == 10 ? 4'hf : (sel == 9 ? 4'd2 : 4'(sel));
        funct[6*i+:6] = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 11)];
      end
      in_valid = L'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      step("rand");
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drain();
    // async reset in the middle of multiplier occupancy
    drive(2'b01, 4'b0010, 6'b011000, 4'd0, 6'd0);
    step("pre_arst");
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 0);
    chk("arst.mult_busy", 32'(mult_busy), 0);
    chk("arst.alucontrol", 32'(alucontrol), 0);
    chk("arst.signd", 32'(signd), 0);
    chk("arst.multseld", 32'(multseld), 0);
    chk("arst.in_ready", 32'(in_ready), 0);
    chk("arst.cnt", 32'(dut.cnt), 0);
    m_ov = '0;
    m_cnt = 0;
    drive('0, 4'd0, 6'd0, 4'd0, 6'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    drive(2'b11, 4'b0000, 6'd0, 4'b0010, 6'b011001);
    step("after_arst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have parameter LANES, default 2: decode lanes per bundle (1..4).
REQ-002 SHALL have parameter MULT_LAT, default 4: shared-multiplier occupancy in cycles (>=1).
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-005 SHALL have port in_valid, input, LANES bits: per-lane instruction valid.
REQ-006 SHALL have port in_ready, output, 1 bit: bundle accepted when in_ready is high and any in_valid bit is high.
REQ-007 SHALL have port funct, input, 6*LANES bits: lane i at [6i+5:6i].
REQ-008 SHALL have port aluop, input, 4*LANES bits: lane i at [4i+3:4i].
REQ-009 SHALL have port flush, input, 1 bit: synchronous pipeline kill.
REQ-010 SHALL have port out_valid, output, LANES bits: registered lane valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the whole bundle.
REQ-012 SHALL have port alucontrol, output, 3*LANES bits.
REQ-013 SHALL have ports signd and multseld, outputs, LANES bits each.
REQ-014 SHALL have port mult_busy, output, 1 bit: shared multiplier occupied.

Function
REQ-015 Per-lane decode SHALL map aluop/funct to {alucontrol, signd, multseld} as follows.
- aluop 0000 add {010,1,0}; 0001 sub {110,1,0}; 0011 or {001,1,0}; 0100 and {000,1,0}.
- aluop 0101 xor {011,1,0}; 0110 slt {111,1,0}; 0111 addiu {010,0,0}; 1000 sltiu {111,0,0}.
- aluop 0010 is R-type, decoded on funct:
  - 100000 {010,1,0}; 100001 {010,0,0}; 100010 {110,1,0}; 100011 {110,0,0}.
  - 100100 {000,1,0}; 100101 {001,1,0}; 101010 {111,1,0}; 101011 {111,0,0}.
  - 100110 {011,1,0}; 011000 mult {000,1,1}; 011001 multu {000,0,1}.
- Any other code is illegal: {000,0,0}. No X is ever driven.
REQ-016 Decode latency SHALL be 1 cycle: outputs registered on acceptance; lanes with in_valid low register out_valid=0.
REQ-017 in_ready SHALL equal (out_valid==0 OR out_ready) AND NOT hazard; hazard = mult_busy AND the incoming bundle contains a valid mult/multu lane.
REQ-018 While out_valid!=0 and out_ready is low, all outputs SHALL hold stable.
REQ-019 On acceptance of a bundle containing a mult lane, the occupancy counter SHALL load MULT_LAT-1, then decrement once per cycle to 0; mult_busy = (counter!=0); MULT_LAT=1 never asserts mult_busy.
REQ-020 A bundle with more than one mult lane SHALL grant multseld=1 only to the lowest-indexed mult lane; higher mult lanes decode as illegal.
REQ-021 Acceptance while draining (out_ready high) SHALL replace the output register in the same cycle with no bubble.
REQ-022 flush SHALL clear out_valid next cycle, force in_ready low for that cycle, and not alter the occupancy counter.

Reset
REQ-023 While reset_n is low: out_valid=0, alucontrol=000, signd=0, multseld=0, counter=0, mult_busy=0, in_ready=0; all asynchronous, including mid-multiply.
REQ-024 in_ready SHALL rise in the first cycle after reset_n deasserts.

Configuration
REQ-025 Macro ALU_DECODE_ILLEGAL_EN defined SHALL add output illegal[LANES], registered with the lane and asserted for valid illegal lanes per REQ-015/REQ-020; reset value 0.
REQ-026 Without ALU_DECODE_ILLEGAL_EN, the illegal port SHALL be absent and decoding SHALL be otherwise identical.

Structure
REQ-027 Package alu_decode_pkg SHALL hold the alucontrol encodings, aluop codes, funct codes and the decoded-lane struct typedef.
REQ-028 Combinational sub-module alu_decode_lane SHALL decode one lane and be instantiated LANES times; the stage owns the registers, handshake and counter.

Verification
REQ-029 Reset released, lane0 aluop=0010 funct=100010 -> next cycle alucontrol=110, signd=1, out_valid[0]=1.
REQ-030 Mult accepted with MULT_LAT=4, then a second mult offered -> mult_busy high for 3 cycles, in_ready low until the counter reaches 0; non-mult bundles still accepted meanwhile.
REQ-031 Both lanes funct=011000 -> multseld=2'b01, illegal=2'b10 (macro on).
REQ-032 out_ready held low for 5 cycles with a new bundle offered -> outputs stable and in_ready low; release -> back-to-back acceptance with no bubble.
REQ-033 flush during a mult -> out_valid=0 next cycle, mult_busy continues counting.
REQ-034 reset_n asserted mid-occupancy -> all outputs and counter zero immediately, no clock edge needed.
